// File: rtl/conv_window_addr_gen.sv
// Sweeps conv-window origins (row, col) over an IMG_H x IMG_W map in raster order
// and streams the flat origin address downstream over a valid/ready handshake.
module conv_window_addr_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 8,
    parameter int CRD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [CRD_W-1:0]  row,
    output logic [CRD_W-1:0]  col,
    output logic              last,
    output logic              busy,
    output logic              done
);

    // Handshake: a window transfers on a rising edge where addr_valid & addr_ready;
    // while valid is high and ready low, addr/row/col/last stay frozen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] MAX_ROW = 32'(IMG_H - K);
    localparam logic [31:0] MAX_COL = 32'(IMG_W - K);
    localparam logic [31:0] STEP    = 32'(STRIDE);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] row_step;
    logic [31:0] col_step;
    logic        row_end;
    logic        col_end;
    logic        xfer;

    // Lookahead in 32 bits so the step can never wrap before the bound compare.
    always_comb begin
        row_step = 32'(row) + STEP;
        col_step = 32'(col) + STEP;
        row_end  = row_step > MAX_ROW;
        col_end  = col_step > MAX_COL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (xfer && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_valid = (state == RUN);
        busy       = (state != IDLE);
        done       = (state == DONE);
        last       = addr_valid & row_end & col_end;
        xfer       = addr_valid & addr_ready;
        addr       = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    end

    // Origins return to 0 after the final window so an idle block presents addr 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (xfer) begin
            if (last) begin
                row <= '0;
                col <= '0;
            end else if (col_end) begin
                col <= '0;
                row <= row_step[CRD_W-1:0];
            end else begin
                col <= col_step[CRD_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench for conv_window_addr_gen: stride-1 instance for full-sweep,
// backpressure, ignored-start and mid-sweep reset cases, plus a stride-2 instance.
module tb_conv_window_addr_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ready;
    logic       valid;
    logic [7:0] addr;
    logic [3:0] row;
    logic [3:0] col;
    logic       last;
    logic       busy;
    logic       done;

    logic       start2;
    logic       ready2;
    logic       valid2;
    logic [7:0] addr2;
    logic [3:0] row2;
    logic [3:0] col2;
    logic       last2;
    logic       busy2;
    logic       done2;

    int tests;
    int failures;
    int xfer_cnt;
    int valid_cyc;
    int xfer2_cnt;

    // Entry packing: {last, row, col, addr}
    logic [16:0] exp_q[$];
    logic [16:0] exp2_q[$];

    conv_window_addr_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr_ready(ready),
        .addr_valid(valid), .addr(addr), .row(row), .col(col),
        .last(last), .busy(busy), .done(done)
    );

    conv_window_addr_gen #(.STRIDE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .addr_ready(ready2),
        .addr_valid(valid2), .addr(addr2), .row(row2), .col(col2),
        .last(last2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failures=%0d", tests, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the stride-1 instance: pops on every transfer and tracks done/hold.
    logic        exp_done;
    logic        held_v;
    logic [16:0] held;
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            exp_done = 1'b0;
            held_v   = 1'b0;
        end else begin
            if (done || exp_done) check("done_pulse", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            if (valid) valid_cyc++;
            else check("last_gated", 32'(last), 0);
            if (valid && held_v) check("hold_stable", {last, row, col, addr}, held);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("FAIL spurious_xfer: got addr %0d, expected no transfer", addr);
                end else begin
                    e = exp_q.pop_front();
                    check("window", {last, row, col, addr}, e);
                    exp_done = e[16];
                end
                xfer_cnt++;
                held_v = 1'b0;
            end else if (valid) begin
                held_v = 1'b1;
                held   = {last, row, col, addr};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    logic exp2_done;
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            exp2_done = 1'b0;
        end else begin
            if (done2 || exp2_done) check("s2_done_pulse", 32'(done2), 32'(exp2_done));
            exp2_done = 1'b0;
            if (!valid2) check("s2_last_gated", 32'(last2), 0);
            if (valid2 && ready2) begin
                if (exp2_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("FAIL s2_spurious_xfer: got addr %0d, expected no transfer", addr2);
                end else begin
                    e = exp2_q.pop_front();
                    check("s2_window", {last2, row2, col2, addr2}, e);
                    exp2_done = e[16];
                end
                xfer2_cnt++;
            end
        end
    end

    task automatic push_s1();
        int a;
        for (int r = 0; r <= 5; r++) begin
            for (int c = 0; c <= 5; c++) begin
                a = r * 8 + c;
                exp_q.push_back({(a == 45), 4'(r), 4'(c), 8'(a)});
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_addr"}, 32'(addr), 0);
        check({tag, "_row"}, 32'(row), 0);
        check({tag, "_col"}, 32'(col), 0);
        check({tag, "_last"}, 32'(last), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // One stride-1 sweep; bp = stall 3 cycles at addr 9, pulses = stray starts,
    // rst_at > 0 = drop rst_n after that many transfers.
    task automatic run_sweep(input bit bp, input bit pulses, input int rst_at, input string tag);
        int base;
        int vbase;
        int hold;
        bit used;
        bit pulsed;
        bit got_done;
        base     = xfer_cnt;
        vbase    = valid_cyc;
        hold     = 0;
        used     = 1'b0;
        pulsed   = 1'b0;
        got_done = 1'b0;
        push_s1();
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_first_valid"}, 32'(valid), 1);
        check({tag, "_first_addr"}, 32'(addr), 0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                if (pulses) start = 1'b1;
                break;
            end
            if (rst_at > 0 && (xfer_cnt - base) == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, "_midrst"});
                exp_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                check({tag, "_midrst_nodone"}, 32'(done), 0);
                check({tag, "_midrst_idle"}, 32'(busy), 0);
                return;
            end
            if (bp && !used && valid && addr == 8'd9) begin
                ready = 1'b0;
                hold  = 3;
                used  = 1'b1;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) ready = 1'b1;
            end
            if (pulses && !pulsed && (xfer_cnt - base) == 10) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        check({tag, "_done_seen"}, 32'(got_done), 1);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_fall"}, 32'(busy), 0);
        check({tag, "_xfers"}, 32'(xfer_cnt - base), 36);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
        if (!bp) check({tag, "_valid_cycles"}, 32'(valid_cyc - vbase), 36);
        else check({tag, "_valid_cycles"}, 32'(valid_cyc - vbase), 39);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_no_restart_busy"}, 32'(busy), 0);
        check({tag, "_no_restart_valid"}, 32'(valid), 0);
    endtask

    logic [7:0] s2_addrs [9];

    initial begin
        bit got2;
        tests     = 0;
        failures  = 0;
        xfer_cnt  = 0;
        valid_cyc = 0;
        xfer2_cnt = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        ready     = 1'b0;
        start2    = 1'b0;
        ready2    = 1'b1;
        s2_addrs  = '{8'd0, 8'd2, 8'd4, 8'd16, 8'd18, 8'd20, 8'd32, 8'd34, 8'd36};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_s2_valid", 32'(valid2), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep(1'b0, 1'b0, 0, "full");
        run_sweep(1'b1, 1'b0, 0, "bp");
        run_sweep(1'b0, 1'b1, 0, "stray_start");
        run_sweep(1'b0, 1'b0, 20, "rst20");
        run_sweep(1'b0, 1'b0, 0, "after_rst");

        for (int i = 0; i < 9; i++) begin
            exp2_q.push_back({(i == 8), 4'(s2_addrs[i] / 8), 4'(s2_addrs[i] % 8), s2_addrs[i]});
        end
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check("s2_first_addr", 32'(addr2), 0);
        got2 = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done2) begin
                got2 = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("s2_done_seen", 32'(got2), 1);
        @(posedge clk); #1;
        check("s2_busy_fall", 32'(busy2), 0);
        check("s2_xfers", 32'(xfer2_cnt), 9);
        check("s2_queue_empty", 32'(exp2_q.size()), 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
